// File: rtl/fg_prog_pkg.sv
// Shared types and sizes for the floating-gate program sequencer.
// Holds the FSM state enum and the frame address widths.
package fg_prog_pkg;

  localparam int DRAIN_BITS  = 5;
  localparam int GATE_BITS   = 2;
  localparam int PULSE_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_PULSE,
    S_RECOVER,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter with terminal-count flag.
// One instance times settle, pulse-high and recovery intervals.
module fg_prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate program pulse sequencer driving the frame decoders.
// Optional FG_PROG_ABORT_EN adds an abort input that ends a command early.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int WIDTH_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DRAIN_BITS-1:0]  cmd_drain,
  input  logic [GATE_BITS-1:0]   cmd_gate,
  input  logic [PULSE_CNT_W-1:0] cmd_pulses,
  input  logic [WIDTH_W-1:0]     cmd_width,
`ifdef FG_PROG_ABORT_EN
  input  logic                   abort,
`endif
  output logic [DRAIN_BITS-1:0]  drain_b,
  output logic [GATE_BITS-1:0]   gate_b,
  output logic                   drain_enable,
  output logic                   gate_enable,
  output logic                   prog,
  output logic                   run,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = (WIDTH_W > 8) ? WIDTH_W : 8;

  state_t                 state;
  state_t                 state_n;
  logic [DRAIN_BITS-1:0]  drain_q;
  logic [GATE_BITS-1:0]   gate_q;
  logic [WIDTH_W-1:0]     width_q;
  logic [WIDTH_W-1:0]     width_m1;
  logic [PULSE_CNT_W-1:0] pulse_q;
  logic                   en_q;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_tc;
  logic                   pulse_dec;
  logic [TW-1:0]          settle_val;
  logic [TW-1:0]          width_val;

  assign settle_val = TW'(SETTLE_CYC - 1);
  assign width_m1   = width_q - WIDTH_W'(1);
  // A zero width still yields a one-cycle pulse.
  assign width_val  = (width_q == '0) ? '0 : TW'(width_m1);

  fg_prog_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    pulse_dec = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) state_n = S_SELECT;
      end
      S_SELECT: begin
        if (pulse_q == '0) begin
          state_n = S_RELEASE;
        end else begin
          state_n  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = settle_val;
        end
      end
      S_SETTLE: begin
        if (tmr_tc) begin
          state_n   = S_PULSE;
          tmr_load  = 1'b1;
          tmr_val   = width_val;
          pulse_dec = 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr_tc) begin
          state_n  = S_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = settle_val;
        end
      end
      S_RECOVER: begin
        if (tmr_tc) begin
          if (pulse_q != '0) begin
            state_n   = S_PULSE;
            tmr_load  = 1'b1;
            tmr_val   = width_val;
            pulse_dec = 1'b1;
          end else begin
            state_n = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
`ifdef FG_PROG_ABORT_EN
    if (abort && (state inside {S_SELECT, S_SETTLE, S_PULSE, S_RECOVER})) begin
      state_n   = S_RELEASE;
      tmr_load  = 1'b0;
      pulse_dec = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      drain_q <= '0;
      gate_q  <= '0;
      width_q <= '0;
      pulse_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state <= state_n;
      en_q  <= (state_n == S_PULSE);
      if (state == S_IDLE && cmd_valid) begin
        drain_q <= cmd_drain;
        gate_q  <= cmd_gate;
        width_q <= cmd_width;
        pulse_q <= cmd_pulses;
      end else if (pulse_dec) begin
        pulse_q <= pulse_q - 1'b1;
      end
    end
  end

  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign prog         = (state inside {S_SELECT, S_SETTLE, S_PULSE, S_RECOVER});
  assign run          = !prog;
  assign done         = (state == S_RELEASE);
  assign drain_b      = drain_q;
  assign gate_b       = gate_q;
  assign drain_enable = en_q;
  assign gate_enable  = en_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Scoreboard bench for fg_prog_sequencer (SETTLE_CYC=4).
// Define FG_PROG_ABORT_EN to also exercise the abort input.
module tb_fg_prog_sequencer;

  localparam int S = 4;

  typedef struct {
    logic [4:0] drain;
    logic [1:0] gate;
    int         npulse;
    int         en_cycles;
    int         busy;
    bit         full;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_drain = '0;
  logic [1:0]  cmd_gate = '0;
  logic [7:0]  cmd_pulses = '0;
  logic [15:0] cmd_width = '0;
`ifdef FG_PROG_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [4:0]  drain_b;
  logic [1:0]  gate_b;
  logic        drain_enable;
  logic        gate_enable;
  logic        prog;
  logic        run;
  logic        busy;
  logic        done;

  int   tests_run = 0;
  int   failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fg_prog_sequencer #(
    .SETTLE_CYC(S),
    .WIDTH_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_drain    (cmd_drain),
    .cmd_gate     (cmd_gate),
    .cmd_pulses   (cmd_pulses),
    .cmd_width    (cmd_width),
`ifdef FG_PROG_ABORT_EN
    .abort        (abort),
`endif
    .drain_b      (drain_b),
    .gate_b       (gate_b),
    .drain_enable (drain_enable),
    .gate_enable  (gate_enable),
    .prog         (prog),
    .run          (run),
    .busy         (busy),
    .done         (done)
  );

  // Monitor: accumulates per-command activity and pops the scoreboard on done.
  initial begin
    int   busy_cnt;
    int   en_cnt;
    int   np;
    logic en_prev;
    logic busy_prev;
    logic [4:0] drain_prev;
    exp_t e;
    busy_cnt = 0; en_cnt = 0; np = 0;
    en_prev = 0; busy_prev = 0; drain_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0; en_cnt = 0; np = 0;
        en_prev = 0; busy_prev = 0;
      end else begin
        if (busy) busy_cnt++;
        if (drain_enable) en_cnt++;
        if (drain_enable && !en_prev) np++;
        if (drain_enable !== gate_enable) begin
          failed++;
          $display("FAIL en_match: drain_en=%b gate_en=%b", drain_enable, gate_enable);
        end
        if (drain_enable && !prog) begin
          failed++;
          $display("FAIL en_outside_pulse: en=%b prog=%b", drain_enable, prog);
        end
        if (busy && busy_prev && drain_b !== drain_prev) begin
          failed++;
          $display("FAIL drain_stable: got %h was %h", drain_b, drain_prev);
        end
        if (done) begin
          tests_run++;
          if (sb.size() == 0) begin
            failed++;
            $display("FAIL sb_empty: done seen with no expected command");
          end else begin
            e = sb.pop_front();
            if (drain_b !== e.drain || gate_b !== e.gate) begin
              failed++;
              $display("FAIL sb_addr: got %h/%h expected %h/%h", drain_b, gate_b, e.drain, e.gate);
            end
            if (e.full) begin
              tests_run++;
              if (np != e.npulse || en_cnt != e.en_cycles || busy_cnt != e.busy) begin
                failed++;
                $display("FAIL sb_timing: got pulses=%0d en=%0d busy=%0d expected %0d/%0d/%0d",
                         np, en_cnt, busy_cnt, e.npulse, e.en_cycles, e.busy);
              end
            end
          end
          busy_cnt = 0; en_cnt = 0; np = 0;
        end
        en_prev    = drain_enable;
        busy_prev  = busy;
        drain_prev = drain_b;
      end
    end
  end

  task automatic load_cmd(input logic [4:0] d, input logic [1:0] g,
                          input logic [7:0] p, input logic [15:0] w,
                          input bit push, input bit full);
    exp_t e;
    int   we;
    we = (w == 0) ? 1 : int'(w);
    cmd_drain  = d;
    cmd_gate   = g;
    cmd_pulses = p;
    cmd_width  = w;
    cmd_valid  = 1'b1;
    e.drain     = d;
    e.gate      = g;
    e.npulse    = int'(p);
    e.en_cycles = int'(p) * we;
    e.busy      = (p == 0) ? 2 : 2 + S + int'(p) * (we + S);
    e.full      = full;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drain_enable) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready !== 1 || busy !== 0 || drain_b !== 0 || gate_b !== 0 ||
        drain_enable !== 0 || gate_enable !== 0 || prog !== 0 || run !== 1 || done !== 0) begin
      failed++;
      $display("FAIL reset_state: rdy=%b busy=%b d=%h g=%h en=%b%b prog=%b run=%b done=%b",
               cmd_ready, busy, drain_b, gate_b, drain_enable, gate_enable, prog, run, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || busy !== 0) begin
      failed++;
      $display("FAIL reset_release: rdy=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    load_cmd(5'h13, 2'd2, 8'd2, 16'd3, 1, 1);
    @(negedge clk);
    tests_run++;
    if (drain_b !== 5'h13 || gate_b !== 2'd2 || prog !== 1 || run !== 0 || cmd_ready !== 0) begin
      failed++;
      $display("FAIL basic_select: d=%h g=%h prog=%b run=%b rdy=%b expected 13/2/1/0/0",
               drain_b, gate_b, prog, run, cmd_ready);
    end
    cmd_valid = 1'b0;
    wait_done(ok);
    tests_run++;
    if (!ok || prog !== 0 || run !== 1 || drain_enable !== 0) begin
      failed++;
      $display("FAIL basic_release: ok=%b prog=%b run=%b en=%b expected 1/0/1/0",
               ok, prog, run, drain_enable);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || done !== 0) begin
      failed++;
      $display("FAIL basic_idle: rdy=%b done=%b expected 1/0", cmd_ready, done);
    end
  endtask

  task automatic test_zero_pulses;
    load_cmd(5'h0a, 2'd1, 8'd0, 16'd7, 1, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (prog !== 1 || done !== 0) begin
      failed++;
      $display("FAIL zp_select: prog=%b done=%b expected 1/0", prog, done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1 || prog !== 0 || run !== 1) begin
      failed++;
      $display("FAIL zp_release: done=%b prog=%b run=%b expected 1/0/1", done, prog, run);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || drain_b !== 5'h0a) begin
      failed++;
      $display("FAIL zp_idle: rdy=%b d=%h expected 1/0a", cmd_ready, drain_b);
    end
  endtask

  task automatic test_zero_width;
    bit ok;
    load_cmd(5'h1f, 2'd3, 8'd1, 16'd0, 1, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL zw_done: got timeout required done");
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok;
    load_cmd(5'h05, 2'd1, 8'd1, 16'd2, 1, 1);
    @(negedge clk);
    load_cmd(5'h1a, 2'd3, 8'd1, 16'd1, 1, 1);
    wait_done(ok);
    tests_run++;
    if (!ok || drain_b !== 5'h05) begin
      failed++;
      $display("FAIL b2b_first: ok=%b d=%h expected 1/05", ok, drain_b);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || drain_b !== 5'h05) begin
      failed++;
      $display("FAIL b2b_idle: rdy=%b d=%h expected 1/05", cmd_ready, drain_b);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (drain_b !== 5'h1a || gate_b !== 2'd3 || prog !== 1) begin
      failed++;
      $display("FAIL b2b_second: d=%h g=%h prog=%b expected 1a/3/1", drain_b, gate_b, prog);
    end
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL b2b_done: got timeout required done");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse;
    bit ok;
    int seen;
    load_cmd(5'h07, 2'd1, 8'd2, 16'd5, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en(ok);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || drain_enable !== 0 || gate_enable !== 0 || prog !== 0 || run !== 1 || busy !== 0) begin
      failed++;
      $display("FAIL rst_pulse: ok=%b en=%b%b prog=%b run=%b busy=%b expected 1/00/0/1/0",
               ok, drain_enable, gate_enable, prog, run, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (drain_enable || gate_enable) seen++;
    end
    tests_run++;
    if (seen != 0 || cmd_ready !== 1) begin
      failed++;
      $display("FAIL rst_after: en_cycles=%0d rdy=%b expected 0/1", seen, cmd_ready);
    end
  endtask

`ifdef FG_PROG_ABORT_EN
  task automatic test_abort;
    bit ok;
    load_cmd(5'h11, 2'd2, 8'd3, 16'd6, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en(ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (!ok || drain_enable !== 0 || gate_enable !== 0 || done !== 1) begin
      failed++;
      $display("FAIL abort_pulse: ok=%b en=%b%b done=%b expected 1/00/1",
               ok, drain_enable, gate_enable, done);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || busy !== 0) begin
      failed++;
      $display("FAIL abort_idle: rdy=%b busy=%b expected 1/0", cmd_ready, busy);
    end
    abort = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1 || busy !== 0 || done !== 0) begin
      failed++;
      $display("FAIL abort_in_idle: rdy=%b busy=%b done=%b expected 1/0/0", cmd_ready, busy, done);
    end
    abort = 1'b0;
    load_cmd(5'h02, 2'd1, 8'd1, 16'd2, 1, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL abort_after: got timeout required done");
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      load_cmd(5'($urandom_range(31)), 2'($urandom_range(3)),
               8'($urandom_range(3)), 16'($urandom_range(4)), 1, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(ok);
      tests_run++;
      if (!ok) begin
        failed++;
        $display("FAIL rand_done: iter %0d got timeout required done", i);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_pulses;
    test_zero_width;
    test_back_to_back;
    test_random;
`ifdef FG_PROG_ABORT_EN
    test_abort;
`endif
    test_reset_mid_pulse;
    tests_run++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
